mining_controller: RTL and testbench

Nonce-sweep sequencer for the SHA-256 mining datapath. Builds each 440-bit candidate message from a fixed header prefix and the current nonce, then runs the message preprocessor. It passes the resulting 512-bit block to the hash core and compares the digest against a 256-bit target. It stops on the first digest below target, at the end of the nonce range, on abort, or on a handshake timeout. It sits between the host/config registers and the preprocessor + hash core pair.

---
 rtl/mining_pkg.sv | 7 +
 rtl/digest_cmp.sv | 10 +
 rtl/mining_controller.sv | 135 +++++++++++++
 tb/tb_mining_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// mining_pkg: shared types and widths for the SHA-256 nonce-sweep controller and its peers
package mining_pkg;
  typedef enum logic [2:0] {IDLE, PREP_KICK, PREP_WAIT, HASH_KICK, HASH_WAIT, COMPARE} mc_state_t;
  localparam int MSG_W = 440;
  localparam int BLOCK_W = 512;
  localparam int DIGEST_W = 256;
endpackage

// File: rtl/digest_cmp.sv
// digest_cmp: unsigned strict less-than between a digest and a target
module digest_cmp #(
  parameter int W = 256
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);
  assign lt = a < b;
endmodule

// File: rtl/mining_controller.sv
// mining_controller: sweeps nonces through preprocessor and hash core until a digest beats the target
module mining_controller import mining_pkg::*; #(
  parameter int NONCE_W  = 32,
  parameter int PREFIX_W = 408,
  parameter int TIMEOUT  = 1024,
  parameter int TMR_W    = 11
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [PREFIX_W-1:0]   prefix,
  input  logic [NONCE_W-1:0]    nonce_start,
  input  logic [NONCE_W-1:0]    nonce_end,
  input  logic [DIGEST_W-1:0]   target,
  output logic                  pre_begin,
  output logic [MSG_W-1:0]      pre_msg,
  input  logic                  pre_done,
  input  logic [BLOCK_W-1:0]    pre_block,
  output logic                  hash_start,
  output logic [BLOCK_W-1:0]    hash_block,
  input  logic                  hash_done,
  input  logic [DIGEST_W-1:0]   hash_digest,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic                  exhausted,
  output logic                  error,
  output logic [NONCE_W-1:0]    found_nonce,
  output logic [31:0]           attempts
);
  mc_state_t state;
  logic [NONCE_W-1:0] nonce_q, end_q;
  logic [DIGEST_W-1:0] target_q, digest_q;
  logic [TMR_W-1:0] tmr;
  logic lt;
  logic tmr_last;
  digest_cmp #(.W(DIGEST_W)) u_cmp (.a(digest_q), .b(target_q), .lt(lt));
  assign pre_msg = {prefix, nonce_q};
  assign busy = state != IDLE;
  // last waiting cycle: a done pulse here still wins over the timeout
  assign tmr_last = tmr == TMR_W'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      nonce_q <= '0;
      end_q <= '0;
      target_q <= '0;
      digest_q <= '0;
      tmr <= '0;
      hash_block <= '0;
      pre_begin <= 1'b0;
      hash_start <= 1'b0;
      done <= 1'b0;
      found <= 1'b0;
      exhausted <= 1'b0;
      error <= 1'b0;
      found_nonce <= '0;
      attempts <= '0;
    end else begin
      pre_begin <= 1'b0;
      hash_start <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        found <= 1'b0;
        exhausted <= 1'b0;
        error <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            nonce_q <= nonce_start;
            end_q <= nonce_end;
            target_q <= target;
            found <= 1'b0;
            exhausted <= 1'b0;
            error <= 1'b0;
            attempts <= '0;
            pre_begin <= 1'b1;
            state <= PREP_KICK;
          end
          PREP_KICK: begin
            tmr <= '0;
            state <= PREP_WAIT;
          end
          PREP_WAIT: begin
            tmr <= tmr + TMR_W'(1);
            if (pre_done) begin
              hash_block <= pre_block;
              hash_start <= 1'b1;
              state <= HASH_KICK;
            end else if (tmr_last) begin
              error <= 1'b1;
              done <= 1'b1;
              state <= IDLE;
            end
          end
          HASH_KICK: begin
            tmr <= '0;
            state <= HASH_WAIT;
          end
          HASH_WAIT: begin
            tmr <= tmr + TMR_W'(1);
            if (hash_done) begin
              digest_q <= hash_digest;
              attempts <= attempts + 32'd1;
              state <= COMPARE;
            end else if (tmr_last) begin
              error <= 1'b1;
              done <= 1'b1;
              state <= IDLE;
            end
          end
          COMPARE: begin
            if (lt) begin
              found <= 1'b1;
              found_nonce <= nonce_q;
              done <= 1'b1;
              state <= IDLE;
            end else if (nonce_q == end_q) begin
              exhausted <= 1'b1;
              done <= 1'b1;
              state <= IDLE;
            end else begin
              nonce_q <= nonce_q + NONCE_W'(1);
              pre_begin <= 1'b1;
              state <= PREP_KICK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mining_controller.sv
// tb_mining_controller: directed sweeps against a sweep-level model with emulated preprocessor and hash core
module tb_mining_controller;
  import mining_pkg::*;
  localparam int TO = 16;
  localparam logic [71:0] PAD = 72'hC35A5AF00D1234BEEF;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [407:0] prefix;
  logic [31:0] nonce_start = '0, nonce_end = '0;
  logic [255:0] target = '0;
  logic pre_begin, hash_start, pre_done = 1'b0, hash_done = 1'b0;
  logic [MSG_W-1:0] pre_msg;
  logic [BLOCK_W-1:0] pre_block = '0, hash_block;
  logic [DIGEST_W-1:0] hash_digest = '0;
  logic busy, done, found, exhausted, error;
  logic [31:0] found_nonce, attempts;
  int checks = 0, failures = 0, cyc = 0;
  bit pre_en = 1, hash_en = 1, abort_on_hash = 0, win_en = 0;
  logic [31:0] win = '0;
  logic [255:0] win_dig = '0, lose_dig = '0, tgt = '0;
  logic [31:0] exp_nonce = '0, exp_fn = '0, exp_att = '0;
  bit exp_found, exp_exh, exp_err, expect_done;
  int st_cyc, pb_cyc, hs_cyc, hd_cyc, pb_count, done_count, m_att;

  always #5 clk = ~clk;

  mining_controller #(.NONCE_W(32), .PREFIX_W(408), .TIMEOUT(TO), .TMR_W(5)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .prefix(prefix),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .pre_begin(pre_begin), .pre_msg(pre_msg), .pre_done(pre_done), .pre_block(pre_block),
    .hash_start(hash_start), .hash_block(hash_block), .hash_done(hash_done), .hash_digest(hash_digest),
    .busy(busy), .done(done), .found(found), .exhausted(exhausted), .error(error),
    .found_nonce(found_nonce), .attempts(attempts)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mkblk(input logic [31:0] n);
    return {PAD, prefix, n};
  endfunction

  // preprocessor stand-in: done two cycles after the kick
  initial forever begin
    @(negedge clk);
    if (pre_begin && pre_en) begin
      repeat (2) @(posedge clk);
      #1 pre_done = 1'b1;
      pre_block = {PAD, pre_msg};
      @(posedge clk);
      #1 pre_done = 1'b0;
      pre_block = '0;
    end
  end

  // hash core stand-in: digest chosen by the nonce carried in the block
  initial forever begin
    @(negedge clk);
    if (hash_start && hash_en) begin
      repeat (3) @(posedge clk);
      #1 hash_done = 1'b1;
      hash_digest = (win_en && hash_block[31:0] == win) ? win_dig : lose_dig;
      if (abort_on_hash) abort = 1'b1;
      @(posedge clk);
      #1 hash_done = 1'b0;
      hash_digest = '0;
      if (abort_on_hash) begin
        abort = 1'b0;
        abort_on_hash = 0;
      end
    end
  end

  // per-cycle comparison against the sweep model
  always @(negedge clk) begin
    cyc++;
    if (n_rst) begin
      if (start && !busy && !abort) st_cyc = cyc;
      if (pre_begin) begin
        chk("pre_msg", pre_msg, {prefix, exp_nonce});
        chk("pre_begin_time", cyc, pb_count == 0 ? st_cyc + 1 : hd_cyc + 2);
        pb_cyc = cyc;
        pb_count++;
      end
      if (hash_start) begin
        chk("hash_block", hash_block, mkblk(exp_nonce));
        hs_cyc = cyc;
      end
      if (hash_done && busy) begin
        hd_cyc = cyc;
        m_att++;
        exp_nonce++;
      end
      if (done) begin
        done_count++;
        chk("done_expected", done, expect_done);
        chk("found", found, exp_found);
        chk("exhausted", exhausted, exp_exh);
        chk("error", error, exp_err);
        chk("attempts", attempts, exp_att);
        if (exp_found) chk("found_nonce", found_nonce, exp_fn);
        chk("done_time", cyc, exp_err ? (pre_en ? hs_cyc : pb_cyc) + TO + 1 : hd_cyc + 2);
      end
    end
  end

  task automatic run(input logic [31:0] ns, input logic [31:0] ne, input bit we, input logic [31:0] w);
    logic [31:0] span, off;
    span = ne - ns;
    off = w - ns;
    exp_err = !(pre_en && hash_en);
    exp_found = !exp_err && we && off <= span;
    exp_exh = !exp_err && !exp_found;
    exp_fn = w;
    exp_att = exp_err ? 32'd0 : exp_found ? off + 1 : span + 1;
    exp_nonce = ns;
    pb_count = 0;
    done_count = 0;
    m_att = 0;
    expect_done = 1;
    win_en = we;
    win = w;
    @(posedge clk);
    #1 nonce_start = ns;
    nonce_end = ne;
    target = tgt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nonce_start = ~ns;
    nonce_end = ~ne;
    target = ~tgt;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_count == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("done_count", done_count, 1);
    chk("pre_begin_count", pb_count, exp_err ? 1 : exp_att);
    @(negedge clk);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    prefix = {24'hABCDEF, {6{64'h0123_4567_89AB_CDEF}}};
    repeat (2) @(negedge clk);
    chk("rst_outs", {pre_begin, hash_start, busy, done, found, exhausted, error}, 0);
    chk("rst_vals", {found_nonce, attempts}, 0);
    chk("rst_block", hash_block, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;

    // single-nonce range with a winning digest
    tgt = 256'h10; win_dig = 256'h1; lose_dig = 256'h20;
    run(32'd5, 32'd5, 1, 32'd5);
    wait_done();
    chk("t1_found", found, 1);
    chk("t1_nonce", found_nonce, 5);
    chk("t1_attempts", attempts, 1);

    // wrapping range, digest equal to target never wins
    tgt = 256'h10; lose_dig = 256'h10;
    run(32'hFFFF_FFFE, 32'h0000_0001, 0, 32'd0);
    wait_done();
    chk("t2_exhausted", exhausted, 1);
    chk("t2_found", found, 0);
    chk("t2_attempts", attempts, 4);
    chk("t2_last_nonce", pre_msg[31:0], 1);

    // early hit inside a longer range
    tgt = {4'h8, 252'h0}; win_dig = tgt - 1; lose_dig = '1;
    run(32'd0, 32'd9, 1, 32'd3);
    wait_done();
    chk("t3_nonce", found_nonce, 3);
    chk("t3_attempts", attempts, 4);

    // hash core never answers
    hash_en = 0;
    run(32'd0, 32'd3, 0, 32'd0);
    wait_done();
    chk("t4_error", error, 1);
    chk("t4_attempts", attempts, 0);
    hash_en = 1;

    // preprocessor never answers
    pre_en = 0;
    run(32'd0, 32'd3, 0, 32'd0);
    wait_done();
    chk("t5_error", error, 1);
    pre_en = 1;

    // abort together with a winning hash_done
    tgt = 256'h10; win_dig = 256'h1; lose_dig = 256'h20;
    abort_on_hash = 1;
    run(32'd7, 32'd7, 1, 32'd7);
    expect_done = 0;
    for (int i = 0; i < 100 && m_att == 0; i++) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_status", {found, exhausted, error}, 0);
    repeat (10) @(posedge clk);
    chk("abort_no_done", done_count, 0);
    run(32'd7, 32'd7, 1, 32'd7);
    wait_done();
    chk("restart_found", found, 1);

    // start while busy leaves the sweep alone
    tgt = {4'h8, 252'h0}; lose_dig = '1;
    run(32'd0, 32'd9, 0, 32'd0);
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    nonce_start = 32'd100;
    nonce_end = 32'd100;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    chk("t7_attempts", attempts, 10);
    chk("t7_exhausted", exhausted, 1);

    // asynchronous reset while waiting on the hash core
    hash_en = 0;
    run(32'd0, 32'd3, 0, 32'd0);
    expect_done = 0;
    repeat (8) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("midrst_outs", {pre_begin, hash_start, busy, done, found, exhausted, error}, 0);
    chk("midrst_vals", {found_nonce, attempts}, 0);
    chk("midrst_block", hash_block, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    hash_en = 1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
